// File: rtl/dmem_dump_pkg.sv
// ---------------------------------------------------------------------------
// dmem_dump_pkg
// Shared types and constants for the data-memory dump controller.
//   dump_state_e : controller states (IDLE, HOLD, WALK, FLUSH, DONE)
//   WORD_SHIFT   : word index -> byte address shift (8-byte words)
// ---------------------------------------------------------------------------
package dmem_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        WALK,
        FLUSH,
        DONE
    } dump_state_e;

    localparam int WORD_SHIFT = 3;

endpackage : dmem_dump_pkg

// File: rtl/dump_out_reg.sv
// ---------------------------------------------------------------------------
// dump_out_reg
// Valid/ready output register for the dump beat stream.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_load            : capture i_addr/i_data and raise o_valid
//   i_clear           : drop o_valid (beat consumed, nothing new to show)
//   i_addr, i_data    : beat to capture
//   o_valid, o_addr,
//   o_data            : registered beat presented to the consumer
// Load has priority over clear. With neither asserted everything holds,
// which keeps a stalled beat stable.
// ---------------------------------------------------------------------------
module dump_out_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_addr,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_addr,
    output logic [W-1:0] o_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] addr_q,  addr_d;
    logic [W-1:0] data_q,  data_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned; that is what keeps this block from inferring latches.
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (i_load) begin
            valid_d = 1'b1;
            addr_d  = i_addr;
            data_d  = i_data;
        end else if (i_clear) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // the pre-edge value, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_addr  = addr_q;
    assign o_data  = data_q;

endmodule : dump_out_reg

// File: rtl/dmem_dump_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_dump_ctrl
// Owns the single data-memory port. In IDLE the CPU MEM stage drives it;
// on a dump request the pipeline is stalled and an internal engine walks
// every word, streaming {byte address, data} over valid/ready, then the CPU
// is released with a one-cycle done pulse.
//
// Ports:
//   i_mclk, i_reset_n        : clock, asynchronous active-low reset
//   i_dump_req               : dump request, sampled in IDLE only
//   i_cpu_memread/_memwrite,
//   i_cpu_addr/_wdata        : CPU MEM-stage access
//   o_cpu_rdata              : load data to CPU (0 while the engine owns port)
//   o_cpu_stall              : freeze the pipeline during HOLD/WALK/FLUSH
//   o_mem_addr/_wdata/_we/_re,
//   i_mem_rdata              : data memory port (combinational read)
//   o_dump_valid/_addr/_data,
//   i_dump_ready             : dump beat stream
//   o_dump_busy              : any state other than IDLE
//   o_dump_done              : one-cycle completion pulse
//   o_dump_count             : beats emitted by the last dump
//
// Build option:
//   DMEM_DUMP_SKIP_ZERO_EN   : when defined, all-zero words are not emitted.
// ---------------------------------------------------------------------------
module dmem_dump_ctrl
    import dmem_dump_pkg::*;
#(
    parameter int N     = 64,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_mclk,
    input  logic          i_reset_n,
    input  logic          i_dump_req,
    input  logic          i_cpu_memread,
    input  logic          i_cpu_memwrite,
    input  logic [N-1:0]  i_cpu_addr,
    input  logic [N-1:0]  i_cpu_wdata,
    output logic [N-1:0]  o_cpu_rdata,
    output logic          o_cpu_stall,
    output logic [N-1:0]  o_mem_addr,
    output logic [N-1:0]  o_mem_wdata,
    output logic          o_mem_we,
    output logic          o_mem_re,
    input  logic [N-1:0]  i_mem_rdata,
    output logic          o_dump_valid,
    input  logic          i_dump_ready,
    output logic [N-1:0]  o_dump_addr,
    output logic [N-1:0]  o_dump_data,
    output logic          o_dump_busy,
    output logic          o_dump_done,
    output logic [AW:0]   o_dump_count
);

    dump_state_e   state_q, state_d;
    logic [AW-1:0] index_q, index_d;
    logic [AW:0]   count_q, count_d;

    logic          out_load;
    logic          out_clear;
    logic          skip_word;
    logic          last_word;
    logic          cpu_owns_port;
    logic [N-1:0]  index_byte_addr;

    assign index_byte_addr = N'(index_q) << WORD_SHIFT;
    assign last_word       = (index_q == AW'(DEPTH - 1));
    assign cpu_owns_port   = (state_q == IDLE);

`ifdef DMEM_DUMP_SKIP_ZERO_EN
    assign skip_word = (i_mem_rdata == '0);
`else
    assign skip_word = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next-state, index and count
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        count_d   = count_q;
        out_load  = 1'b0;
        out_clear = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_dump_req) begin
                    state_d = HOLD;
                end
            end

            HOLD: begin
                index_d = '0;
                count_d = '0;
                state_d = WALK;
            end

            WALK: begin
                if (skip_word) begin
                    // A skipped word never touches the output register, so it
                    // advances even while a beat is stalled; a pending beat
                    // accepted this cycle simply leaves the register empty.
                    index_d   = index_q + AW'(1);
                    out_clear = o_dump_valid && i_dump_ready;
                    if (last_word) begin
                        state_d = (o_dump_valid && !i_dump_ready) ? FLUSH : DONE;
                    end
                end else if (!o_dump_valid || i_dump_ready) begin
                    out_load = 1'b1;
                    index_d  = index_q + AW'(1);
                    count_d  = count_q + (AW+1)'(1);
                    if (last_word) begin
                        state_d = FLUSH;
                    end
                end
            end

            FLUSH: begin
                // The register is always full on entry; the !valid term only
                // guarantees FLUSH can never wedge.
                if (!o_dump_valid || i_dump_ready) begin
                    out_clear = 1'b1;
                    state_d   = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_mclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            index_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            count_q <= count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Memory port arbitration
    // -----------------------------------------------------------------------
    always_comb begin
        if (cpu_owns_port) begin
            o_mem_addr  = i_cpu_addr;
            o_mem_wdata = i_cpu_wdata;
            o_mem_we    = i_cpu_memwrite;
            o_mem_re    = i_cpu_memread;
            o_cpu_rdata = i_mem_rdata;
        end else begin
            o_mem_addr  = index_byte_addr;
            o_mem_wdata = '0;
            o_mem_we    = 1'b0;
            o_mem_re    = (state_q == WALK);
            o_cpu_rdata = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Beat output register
    // -----------------------------------------------------------------------
    dump_out_reg #(
        .W (N)
    ) u_out_reg (
        .clk     (i_mclk),
        .rst_n   (i_reset_n),
        .i_load  (out_load),
        .i_clear (out_clear),
        .i_addr  (index_byte_addr),
        .i_data  (i_mem_rdata),
        .o_valid (o_dump_valid),
        .o_addr  (o_dump_addr),
        .o_data  (o_dump_data)
    );

    // DONE releases the pipeline one cycle before the port returns to it.
    assign o_cpu_stall  = (state_q == HOLD) || (state_q == WALK) || (state_q == FLUSH);
    assign o_dump_busy  = (state_q != IDLE);
    assign o_dump_done  = (state_q == DONE);
    assign o_dump_count = count_q;

endmodule : dmem_dump_ctrl

// File: tb/tb_dmem_dump_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_dump_ctrl
// Self-checking bench for dmem_dump_ctrl. The expected beat stream is the
// list of (word index * 8, word) taken from a reference copy of memory,
// filtered for zero words when DMEM_DUMP_SKIP_ZERO_EN is defined.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_dmem_dump_ctrl;

    localparam int N     = 64;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int LIMIT = 400;

    logic          i_mclk;
    logic          i_reset_n;
    logic          i_dump_req;
    logic          i_cpu_memread;
    logic          i_cpu_memwrite;
    logic [N-1:0]  i_cpu_addr;
    logic [N-1:0]  i_cpu_wdata;
    logic [N-1:0]  o_cpu_rdata;
    logic          o_cpu_stall;
    logic [N-1:0]  o_mem_addr;
    logic [N-1:0]  o_mem_wdata;
    logic          o_mem_we;
    logic          o_mem_re;
    logic [N-1:0]  i_mem_rdata;
    logic          o_dump_valid;
    logic          i_dump_ready;
    logic [N-1:0]  o_dump_addr;
    logic [N-1:0]  o_dump_data;
    logic          o_dump_busy;
    logic          o_dump_done;
    logic [AW:0]   o_dump_count;

    logic [N-1:0]  mem     [DEPTH];
    logic [N-1:0]  ref_mem [DEPTH];
    logic [N-1:0]  exp_addr_q [$];
    logic [N-1:0]  exp_data_q [$];
    int            model_n;

    int total = 0;
    int bad   = 0;

    dmem_dump_ctrl #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .i_mclk         (i_mclk),
        .i_reset_n      (i_reset_n),
        .i_dump_req     (i_dump_req),
        .i_cpu_memread  (i_cpu_memread),
        .i_cpu_memwrite (i_cpu_memwrite),
        .i_cpu_addr     (i_cpu_addr),
        .i_cpu_wdata    (i_cpu_wdata),
        .o_cpu_rdata    (o_cpu_rdata),
        .o_cpu_stall    (o_cpu_stall),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .o_mem_we       (o_mem_we),
        .o_mem_re       (o_mem_re),
        .i_mem_rdata    (i_mem_rdata),
        .o_dump_valid   (o_dump_valid),
        .i_dump_ready   (i_dump_ready),
        .o_dump_addr    (o_dump_addr),
        .o_dump_data    (o_dump_data),
        .o_dump_busy    (o_dump_busy),
        .o_dump_done    (o_dump_done),
        .o_dump_count   (o_dump_count)
    );

    initial begin
        i_mclk = 1'b0;
        forever #5 i_mclk = ~i_mclk;
    end

    // Data memory: combinational read, write on the rising edge.
    assign i_mem_rdata = mem[o_mem_addr[AW+2:3]];

    always @(posedge i_mclk) begin
        if (o_mem_we) mem[o_mem_addr[AW+2:3]] = o_mem_wdata;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 'h%0h, want 'h%0h", tag, obs, exp);
        end
    endtask

    // Expected beats: every word in index order, byte address = index * 8.
    function automatic void build_model();
        exp_addr_q.delete();
        exp_data_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
`ifdef DMEM_DUMP_SKIP_ZERO_EN
            if (ref_mem[i] == '0) continue;
`endif
            exp_addr_q.push_back(64'(i) * 64'd8);
            exp_data_q.push_back(ref_mem[i]);
        end
        model_n = exp_addr_q.size();
    endfunction

    task automatic set_word(input int idx, input logic [N-1:0] val);
        mem[idx]     = val;
        ref_mem[idx] = val;
    endtask

    // mode: 0 = ready high, 1 = ready 1-0-0 repeating, 2 = random ready.
    // Returns in the IDLE cycle after done, or after a reset abort.
    task automatic run_dump(input int mode, input bit hold_req, input int extra_req_cyc,
                            input int abort_cyc, input bit store_en,
                            input logic [N-1:0] st_addr, input logic [N-1:0] st_data);
        int            cyc         = 0;
        int            first_valid = -1;
        int            done_cyc    = -1;
        int            done_cnt    = 0;
        int            beats       = 0;
        int            stall_gaps  = 0;
        int            port_leaks  = 0;
        bit            prev_hold   = 1'b0;
        bit            finished    = 1'b0;
        bit            strobes;
        logic [N-1:0]  prev_addr   = '0;
        logic [N-1:0]  prev_data   = '0;

        i_dump_req   = 1'b1;
        i_dump_ready = 1'b1;
        if (store_en) begin
            i_cpu_memwrite = 1'b1;
            i_cpu_addr     = st_addr;
            i_cpu_wdata    = st_data;
            ref_mem[st_addr[AW+2:3]] = st_data;
        end
        build_model();
        @(negedge i_mclk);
        check("req_cycle_stall", 64'(o_cpu_stall), 64'd0);
        @(posedge i_mclk); #1;

        while (!finished && cyc < LIMIT) begin
            // The stalled CPU keeps asserting a junk load/store; none of it may
            // reach memory or come back as load data.
            strobes        = (cyc >= 1) && (done_cyc < 0);
            i_cpu_memwrite = strobes;
            i_cpu_memread  = strobes;
            i_cpu_addr     = strobes ? 64'h8 : 64'h0;
            i_cpu_wdata    = strobes ? 64'hBAD : 64'h0;
            i_dump_req     = hold_req || (cyc == extra_req_cyc);
            case (mode)
                0:       i_dump_ready = 1'b1;
                1:       i_dump_ready = (cyc % 3 == 0);
                default: i_dump_ready = 1'($urandom_range(0, 1));
            endcase

            if (cyc == abort_cyc) begin
                i_cpu_memwrite = 1'b0;
                i_cpu_memread  = 1'b0;
                i_dump_req     = 1'b0;
                i_reset_n      = 1'b0;
                #1;
                check("abort_valid", 64'(o_dump_valid), 64'd0);
                check("abort_stall", 64'(o_cpu_stall), 64'd0);
                check("abort_done",  64'(o_dump_done), 64'd0);
                repeat (2) @(posedge i_mclk);
                #1;
                i_reset_n = 1'b1;
                @(negedge i_mclk);
                check("abort_idle_busy", 64'(o_dump_busy), 64'd0);
                check("abort_count",     64'(o_dump_count), 64'd0);
                check("abort_no_done",   64'(o_dump_done), 64'd0);
                return;
            end

            @(negedge i_mclk);
            if (cyc == 0) check("stall_rise", 64'(o_cpu_stall), 64'd1);
            if (strobes && !o_dump_done && (o_mem_we || o_cpu_rdata != '0)) port_leaks++;
            if (done_cyc < 0 && !o_dump_done && !o_cpu_stall) stall_gaps++;
            if (o_dump_valid && first_valid < 0) first_valid = cyc;

            if (prev_hold) begin
                check("hold_valid", 64'(o_dump_valid), 64'd1);
                check("hold_addr",  o_dump_addr, prev_addr);
                check("hold_data",  o_dump_data, prev_data);
            end

            if (o_dump_valid && i_dump_ready) begin
                beats++;
                if (exp_addr_q.size() > 0) begin
                    check("beat_addr", o_dump_addr, exp_addr_q.pop_front());
                    check("beat_data", o_dump_data, exp_data_q.pop_front());
                end
            end
            prev_hold = o_dump_valid && !i_dump_ready;
            prev_addr = o_dump_addr;
            prev_data = o_dump_data;

            if (o_dump_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check("done_stall", 64'(o_cpu_stall), 64'd0);
                    check("done_count", 64'(o_dump_count), 64'(model_n));
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                finished = 1'b1;
                check("idle_after_done", 64'(o_dump_busy), 64'd0);
            end
            @(posedge i_mclk); #1;
            cyc++;
        end

        check("done_seen",   64'(done_cyc >= 0), 64'd1);
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("beats",       64'(beats), 64'(model_n));
        check("stall_gaps",  64'(stall_gaps), 64'd0);
        check("port_leaks",  64'(port_leaks), 64'd0);
        if (mode == 0 && model_n == DEPTH) begin
            // First beat two edges after the sampling edge; done DEPTH+2 edges
            // after it, i.e. DEPTH+3 cycles after the request cycle.
            check("first_valid_lat", 64'(first_valid), 64'd2);
            check("done_lat",        64'(done_cyc), 64'(DEPTH + 2));
        end
    endtask

    initial begin
        int idle_busy;
        bit got_done;

        i_reset_n      = 1'b0;
        i_dump_req     = 1'b0;
        i_cpu_memread  = 1'b0;
        i_cpu_memwrite = 1'b0;
        i_cpu_addr     = '0;
        i_cpu_wdata    = '0;
        i_dump_ready   = 1'b0;
        for (int i = 0; i < DEPTH; i++) set_word(i, 64'(i + 1));

        // Reset state
        repeat (2) @(negedge i_mclk);
        check("rst_valid", 64'(o_dump_valid), 64'd0);
        check("rst_addr",  o_dump_addr, 64'd0);
        check("rst_data",  o_dump_data, 64'd0);
        check("rst_done",  64'(o_dump_done), 64'd0);
        check("rst_count", 64'(o_dump_count), 64'd0);
        check("rst_stall", 64'(o_cpu_stall), 64'd0);
        check("rst_busy",  64'(o_dump_busy), 64'd0);
        @(posedge i_mclk); #1;
        i_reset_n = 1'b1;

        // CPU pass-through in IDLE
        i_cpu_memread = 1'b1;
        i_cpu_addr    = 64'h18;
        #1;
        check("cpu_load_data", o_cpu_rdata, ref_mem[3]);
        check("cpu_load_addr", o_mem_addr, 64'h18);
        check("cpu_load_re",   64'(o_mem_re), 64'd1);
        @(posedge i_mclk); #1;
        i_cpu_memread  = 1'b0;
        i_cpu_memwrite = 1'b1;
        i_cpu_addr     = 64'h20;
        i_cpu_wdata    = 64'h1234_5678;
        ref_mem[4]     = 64'h1234_5678;
        #1;
        check("cpu_store_we",   64'(o_mem_we), 64'd1);
        check("cpu_store_data", o_mem_wdata, 64'h1234_5678);
        @(posedge i_mclk); #1;
        i_cpu_memwrite = 1'b0;
        i_cpu_memread  = 1'b1;
        #1;
        check("cpu_store_readback", o_cpu_rdata, ref_mem[4]);
        @(posedge i_mclk); #1;
        i_cpu_memread = 1'b0;
        set_word(4, 64'd5);

        // Preload i+1: ready high, then ready 1-0-0
        run_dump(0, 1'b0, -1, -1, 1'b0, '0, '0);
        run_dump(1, 1'b0, -1, -1, 1'b0, '0, '0);

        // Request in the same cycle as a CPU store to 0x10
        run_dump(0, 1'b0, -1, -1, 1'b1, 64'h10, 64'hAB);

        // Second request while busy is ignored
        run_dump(2, 1'b0, 10, -1, 1'b0, '0, '0);
        idle_busy = 0;
        repeat (3) begin
            @(posedge i_mclk); #1;
            @(negedge i_mclk);
            if (o_dump_busy) idle_busy++;
        end
        check("no_retrigger", 64'(idle_busy), 64'd0);

        // Reset mid-WALK at index 10, then a clean dump
        @(posedge i_mclk); #1;
        run_dump(0, 1'b0, -1, 11, 1'b0, '0, '0);
        @(posedge i_mclk); #1;
        run_dump(0, 1'b0, -1, -1, 1'b0, '0, '0);

        // Random contents (about a quarter zero) with random ready
        for (int i = 0; i < DEPTH; i++) begin
            logic [N-1:0] r;
            r = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) r = '0;
            set_word(i, r);
        end
        run_dump(2, 1'b0, -1, -1, 1'b0, '0, '0);

        // Held request re-triggers: HOLD two cycles after done
        run_dump(0, 1'b1, -1, -1, 1'b0, '0, '0);
        @(posedge i_mclk); #1;
        i_dump_req = 1'b0;
        @(negedge i_mclk);
        check("retrigger_stall", 64'(o_cpu_stall), 64'd1);
        check("retrigger_busy",  64'(o_dump_busy), 64'd1);
        got_done = 1'b0;
        for (int i = 0; i < LIMIT && !got_done; i++) begin
            @(negedge i_mclk);
            if (o_dump_done) got_done = 1'b1;
        end
        check("retrigger_done",  64'(got_done), 64'd1);
        check("retrigger_count", 64'(o_dump_count), 64'(model_n));

`ifdef DMEM_DUMP_SKIP_ZERO_EN
        // Only mem[5] non-zero: one beat at 0x28
        for (int i = 0; i < DEPTH; i++) set_word(i, '0);
        set_word(5, 64'd7);
        @(posedge i_mclk); #1;
        run_dump(0, 1'b0, -1, -1, 1'b0, '0, '0);
        check("skip_count", 64'(o_dump_count), 64'd1);
`endif

        repeat (2) @(posedge i_mclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dmem_dump_ctrl
